// File: rtl/karatsuba_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : karatsuba_mult_pipe
//  Description : 3-stage pipelined Karatsuba WIDTH x WIDTH multiplier with
//                valid/ready handshake, per-operation signed/unsigned mode
//                and a user tag that travels with each operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_mult_pipe #(
    parameter int WIDTH = 16,   // must be even and >= 4
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int c_half = WIDTH / 2;
    localparam int c_pw   = 2 * WIDTH;

    // Stage 1 registers: split magnitudes, half sums, sign, tag
    logic                 r_s1_valid;
    logic [c_half-1:0]    r_s1_ah, r_s1_al, r_s1_bh, r_s1_bl;
    logic [c_half:0]      r_s1_sa, r_s1_sb;
    logic                 r_s1_neg;
    logic [TAG_W-1:0]     r_s1_tag;

    // Stage 2 registers: the three partial products
    logic                 r_s2_valid;
    logic [2*c_half-1:0]  r_s2_z0, r_s2_z2;
    logic [2*c_half+1:0]  r_s2_pm;
    logic                 r_s2_neg;
    logic [TAG_W-1:0]     r_s2_tag;

    // Stage 3 registers: final result presented on the outputs
    logic                 r_s3_valid;
    logic [c_pw-1:0]      r_s3_prod;
    logic [TAG_W-1:0]     r_s3_tag;

    logic                 w_adv;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;
    logic [2*c_half+1:0]  w_z1;
    logic [c_pw-1:0]      w_m;
    logic [c_pw-1:0]      w_prod;

    // Whole pipeline moves as one; a held output freezes every stage
    assign w_adv     = !r_s3_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_s3_valid;
    assign prod      = r_s3_prod;
    assign out_tag   = r_s3_tag;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid;

    // Magnitudes; negating -2^(W-1) in W bits yields 2^(W-1) as an unsigned value
    assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // Capture accepted operands, split them and form the half sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_ah    <= '0;
            r_s1_al    <= '0;
            r_s1_bh    <= '0;
            r_s1_bl    <= '0;
            r_s1_sa    <= '0;
            r_s1_sb    <= '0;
            r_s1_neg   <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_ah  <= w_a_mag[WIDTH-1:c_half];
                r_s1_al  <= w_a_mag[c_half-1:0];
                r_s1_bh  <= w_b_mag[WIDTH-1:c_half];
                r_s1_bl  <= w_b_mag[c_half-1:0];
                r_s1_sa  <= {1'b0, w_a_mag[WIDTH-1:c_half]} + {1'b0, w_a_mag[c_half-1:0]};
                r_s1_sb  <= {1'b0, w_b_mag[WIDTH-1:c_half]} + {1'b0, w_b_mag[c_half-1:0]};
                r_s1_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_s1_tag <= in_tag;
            end
        end
    end

    // Form the three half-width products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_z0    <= '0;
            r_s2_z2    <= '0;
            r_s2_pm    <= '0;
            r_s2_neg   <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_z0  <= r_s1_al * r_s1_bl;
                r_s2_z2  <= r_s1_ah * r_s1_bh;
                r_s2_pm  <= r_s1_sa * r_s1_sb;
                r_s2_neg <= r_s1_neg;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    // Middle term equals aH*bL + aL*bH, so it is never negative and its MSB is always zero
    assign w_z1 = r_s2_pm - {2'b00, r_s2_z2} - {2'b00, r_s2_z0};

    // Recombine the magnitude in full product width, then apply the sign
    assign w_m = ({{WIDTH{1'b0}}, r_s2_z2} << WIDTH)
               + ({{(WIDTH-2){1'b0}}, w_z1} << c_half)
               + {{WIDTH{1'b0}}, r_s2_z0};
    assign w_prod = r_s2_neg ? -w_m : w_m;

    // Register the final product; it holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
            r_s3_tag   <= '0;
        end else if (w_adv) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_prod <= w_prod;
                r_s3_tag  <= r_s2_tag;
            end
        end
    end

endmodule
`default_nettype wire
